// File: rtl/vga_mode_pkg.sv
// Shared constants, mode encodings and parser types for the VGA mode scheduler.
package vga_mode_pkg;

  localparam logic [7:0] HDR          = 8'hA5;
  localparam logic [7:0] CMD_SET_MODE = 8'h01;
  localparam logic [7:0] CMD_SET_THR  = 8'h02;
  localparam logic [7:0] CMD_QUERY    = 8'h03;
  localparam logic [7:0] ACK          = 8'h06;
  localparam logic [7:0] NAK          = 8'h15;

  localparam logic [1:0] MODE_RGB   = 2'd1;
  localparam logic [1:0] MODE_GRAY  = 2'd2;
  localparam logic [1:0] MODE_SOBEL = 2'd3;

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_CMD = 2'd1,
    S_ARG = 2'd2,
    S_CHK = 2'd3
  } parser_state_t;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] arg;
    logic       ok;
  } pkt_t;

endpackage

// File: rtl/vga_cmd_parser.sv
// Command packet parser: header sync, byte capture, checksum and inter-byte timeout.
module vga_cmd_parser
  import vga_mode_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 250000
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       pkt_stb,
  output pkt_t       pkt,
  output logic       tout
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  parser_state_t state;
  logic [7:0]    cmd_q;
  logic [7:0]    arg_q;
  logic [CW-1:0] cnt;

  // A byte arriving on the expiry cycle wins over the timeout.
  assign tout    = (state != S_HDR) && !rx_done && (cnt == TO_LAST);
  assign pkt_stb = rx_done && (state == S_CHK);
  assign pkt     = '{cmd: cmd_q, arg: arg_q, ok: (rx_data == (HDR ^ cmd_q ^ arg_q))};

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state <= S_HDR;
      cmd_q <= '0;
      arg_q <= '0;
      cnt   <= '0;
    end else if (rx_done) begin
      cnt <= '0;
      unique case (state)
        S_HDR: if (rx_data == HDR) state <= S_CMD;
        S_CMD: begin cmd_q <= rx_data; state <= S_ARG; end
        S_ARG: begin arg_q <= rx_data; state <= S_CHK; end
        S_CHK: state <= S_HDR;
        default: state <= S_HDR;
      endcase
    end else if (tout) begin
      state <= S_HDR;
      cnt   <= '0;
    end else if (state != S_HDR) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vga_mode_sched.sv
// Frame-synchronous mode/threshold scheduler: pending registers committed at vsync start, ACK/NAK responses.
module vga_mode_sched
  import vga_mode_pkg::*;
#(
  parameter logic        VSYNC_ACT   = 1'b0,
  parameter int unsigned TIMEOUT_CYC = 250000,
  parameter logic [7:0]  THRESH_RST  = 8'h80
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       vsync_ref,
  output logic [1:0] mode_sel,
  output logic [7:0] sobel_thresh,
  output logic       commit,
  output logic       pending,
  output logic       cmd_err,
  output logic       ack_valid,
  output logic [7:0] ack_data,
  input  logic       ack_ready
);

  logic       pkt_stb;
  pkt_t       pkt;
  logic       tout;
  logic       vsync_q;
  logic       boundary;
  logic       set_mode, set_thr, query, pkt_err;
  logic       dirty_mode, dirty_thr, dirty_mode_n, dirty_thr_n;
  logic [1:0] pend_mode;
  logic [7:0] pend_thresh;
  logic [7:0] resp_byte;

  vga_cmd_parser #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_parser (
    .pclk    (pclk),
    .rst_n   (rst_n),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .pkt_stb (pkt_stb),
    .pkt     (pkt),
    .tout    (tout)
  );

  assign boundary = (vsync_ref == VSYNC_ACT) && (vsync_q != VSYNC_ACT);
  assign set_mode = pkt_stb && pkt.ok && (pkt.cmd == CMD_SET_MODE) &&
                    (pkt.arg[7:2] == '0) && (pkt.arg[1:0] != 2'd0);
  assign set_thr  = pkt_stb && pkt.ok && (pkt.cmd == CMD_SET_THR);
  assign query    = pkt_stb && pkt.ok && (pkt.cmd == CMD_QUERY);
  assign pkt_err  = pkt_stb && !(set_mode || set_thr || query);

  // The boundary clears the old dirty state; a set landing in the same cycle re-arms it for the next frame.
  assign dirty_mode_n = set_mode || (dirty_mode && !boundary);
  assign dirty_thr_n  = set_thr  || (dirty_thr  && !boundary);

  always_comb begin
    resp_byte = NAK;
    if (set_mode || set_thr) resp_byte = ACK;
    else if (query)          resp_byte = {6'b0, mode_sel};
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      vsync_q      <= ~VSYNC_ACT;
      mode_sel     <= MODE_RGB;
      sobel_thresh <= THRESH_RST;
      pend_mode    <= MODE_RGB;
      pend_thresh  <= THRESH_RST;
      dirty_mode   <= 1'b0;
      dirty_thr    <= 1'b0;
      commit       <= 1'b0;
      pending      <= 1'b0;
      cmd_err      <= 1'b0;
      ack_valid    <= 1'b0;
      ack_data     <= 8'h00;
    end else begin
      vsync_q <= vsync_ref;
      commit  <= boundary && (dirty_mode || dirty_thr);
      if (boundary && dirty_mode) mode_sel     <= pend_mode;
      if (boundary && dirty_thr)  sobel_thresh <= pend_thresh;
      if (set_mode) pend_mode   <= pkt.arg[1:0];
      if (set_thr)  pend_thresh <= pkt.arg;
      dirty_mode <= dirty_mode_n;
      dirty_thr  <= dirty_thr_n;
      pending    <= dirty_mode_n || dirty_thr_n;
      cmd_err    <= tout || pkt_err;
      if (pkt_stb) begin
        ack_valid <= 1'b1;
        ack_data  <= resp_byte;
      end else if (ack_ready) begin
        ack_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_mode_sched.sv
// Scoreboard bench for vga_mode_sched: packet-level reference model feeds expectation queues, a monitor checks outputs.
module tb_vga_mode_sched;

  localparam logic        VSYNC_ACT = 1'b0;
  localparam int unsigned TO        = 40;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       vsync_ref;
  logic [1:0] mode_sel;
  logic [7:0] sobel_thresh;
  logic       commit, pending, cmd_err, ack_valid;
  logic [7:0] ack_data;
  logic       ack_ready;

  vga_mode_sched #(.VSYNC_ACT(VSYNC_ACT), .TIMEOUT_CYC(TO), .THRESH_RST(8'h80)) dut (
    .pclk(pclk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done), .vsync_ref(vsync_ref),
    .mode_sel(mode_sel), .sobel_thresh(sobel_thresh), .commit(commit), .pending(pending),
    .cmd_err(cmd_err), .ack_valid(ack_valid), .ack_data(ack_data), .ack_ready(ack_ready)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct { int c; logic [1:0] m; logic [7:0] t; } cm_t;
  logic [7:0] exp_ack_q[$];
  int         exp_err_q[$];
  cm_t        exp_cm_q[$];
  logic [7:0] byte_q[$];
  logic [1:0] m_mode, pm;
  logic [7:0] m_thr, pt;
  bit         dm, dt, m_av;
  logic       m_vs_prev;
  int         idle;

  bit   vs_auto  = 1'b0;
  logic vs_force = ~VSYNC_ACT;
  bit   rand_rdy = 1'b0;

  task automatic model_reset();
    m_mode = 2'd1; m_thr = 8'h80; pm = 2'd1; pt = 8'h80;
    dm = 0; dt = 0; m_av = 0; idle = 0;
    m_vs_prev = ~VSYNC_ACT;
    byte_q.delete(); exp_ack_q.delete(); exp_err_q.delete(); exp_cm_q.delete();
  endtask

  task automatic respond(input logic [7:0] r);
    if (m_av) void'(exp_ack_q.pop_back());
    exp_ack_q.push_back(r);
    m_av = 1;
  endtask

  task automatic eval_pkt(input logic [1:0] old_mode);
    logic [7:0] c, a;
    bit good;
    c = byte_q[1]; a = byte_q[2];
    good = 0;
    if (byte_q[3] == (byte_q[0] ^ c ^ a)) begin
      if (c == 8'h01 && a >= 8'd1 && a <= 8'd3) begin
        pm = a[1:0]; dm = 1; respond(8'h06); good = 1;
      end else if (c == 8'h02) begin
        pt = a; dt = 1; respond(8'h06); good = 1;
      end else if (c == 8'h03) begin
        respond({6'b0, old_mode}); good = 1;
      end
    end
    if (!good) begin
      respond(8'h15);
      exp_err_q.push_back(cyc + 1);
    end
  endtask

  task automatic model_cycle(input logic rd, input logic [7:0] d, input logic vs);
    logic [1:0] old_mode;
    bit bnd;
    old_mode = m_mode;
    bnd = (vs == VSYNC_ACT) && (m_vs_prev != VSYNC_ACT);
    m_vs_prev = vs;
    if (bnd && (dm || dt)) begin
      if (dm) m_mode = pm;
      if (dt) m_thr = pt;
      dm = 0; dt = 0;
      exp_cm_q.push_back('{cyc + 1, m_mode, m_thr});
    end
    if (m_av && ack_ready) m_av = 0;
    if (rd) begin
      idle = 0;
      if (byte_q.size() != 0 || d == 8'hA5) byte_q.push_back(d);
      if (byte_q.size() == 4) begin
        eval_pkt(old_mode);
        byte_q.delete();
      end
    end else if (byte_q.size() != 0) begin
      idle++;
      if (idle >= int'(TO)) begin
        exp_err_q.push_back(cyc + 1);
        byte_q.delete();
        idle = 0;
      end
    end
  endtask

  task automatic step(input logic rd, input logic [7:0] d);
    logic vs;
    vs = vs_auto ? (((cyc % 57) < 4) ? VSYNC_ACT : ~VSYNC_ACT) : vs_force;
    if (rand_rdy) ack_ready = ($urandom_range(0, 3) != 0);
    rx_done = rd; rx_data = d; vsync_ref = vs;
    model_cycle(rd, d, vs);
    @(posedge pclk); #1;
    rx_done = 1'b0;
    chk("mode_sel", 32'(mode_sel), 32'(m_mode));
    chk("sobel_thresh", 32'(sobel_thresh), 32'(m_thr));
    chk("pending", 32'(pending), 32'(dm | dt));
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b0, b1, b2, b3, input int gap);
    logic [7:0] b[4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, b[i]);
      idle_n(gap);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00; vsync_ref = ~VSYNC_ACT;
    repeat (3) @(posedge pclk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_reset_vals();
    chk("rst_mode_sel", 32'(mode_sel), 32'd1);
    chk("rst_sobel_thresh", 32'(sobel_thresh), 32'h80);
    chk("rst_commit", 32'(commit), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_cmd_err", 32'(cmd_err), 32'd0);
    chk("rst_ack_valid", 32'(ack_valid), 32'd0);
    chk("rst_ack_data", 32'(ack_data), 32'h00);
  endtask

  // Monitor: pops expectations whenever the DUT presents a response, error or commit.
  always @(negedge pclk) begin
    if (rst_n === 1'b1) begin
      if (ack_valid && ack_ready) begin
        if (exp_ack_q.size() == 0) chk("ack_unexpected", 32'(ack_data), 32'hFFFF_FFFF);
        else chk("ack_data", 32'(ack_data), 32'(exp_ack_q.pop_front()));
      end
      if (cmd_err) begin
        if (exp_err_q.size() == 0) chk("cmd_err_unexpected", 32'(cyc), 32'hFFFF_FFFF);
        else chk("cmd_err_cycle", 32'(cyc), 32'(exp_err_q.pop_front()));
      end
      if (commit) begin
        if (exp_cm_q.size() == 0) chk("commit_unexpected", 32'(cyc), 32'hFFFF_FFFF);
        else begin
          cm_t e;
          e = exp_cm_q.pop_front();
          chk("commit_cycle", 32'(cyc), 32'(e.c));
          chk("commit_mode", 32'(mode_sel), 32'(e.m));
          chk("commit_thresh", 32'(sobel_thresh), 32'(e.t));
        end
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rx_done = 1'b0; rx_data = 8'h00; vsync_ref = ~VSYNC_ACT; ack_ready = 1'b1;
    model_reset();
    do_reset();
    check_reset_vals();

    // Set mode 3, committed at the next vsync edge
    send(8'hA5, 8'h01, 8'h03, 8'hA7, 0);
    idle_n(3);
    chk("set_pending_before_vsync", 32'(pending), 32'd1);
    vs_force = VSYNC_ACT; idle_n(3);
    vs_force = ~VSYNC_ACT; idle_n(2);
    chk("mode_after_commit", 32'(mode_sel), 32'd3);

    // Two fields within one frame, single commit
    send(8'hA5, 8'h02, 8'h40, 8'hE7, 1);
    send(8'hA5, 8'h01, 8'h02, 8'hA6, 0);
    vs_force = VSYNC_ACT; idle_n(2);
    vs_force = ~VSYNC_ACT; idle_n(2);
    chk("thresh_after_commit", 32'(sobel_thresh), 32'h40);

    // Bad argument and bad checksum
    send(8'hA5, 8'h01, 8'h05, 8'hA1, 0);
    idle_n(2);
    send(8'hA5, 8'h01, 8'h03, 8'h00, 2);
    idle_n(2);

    // Timeout after a partial packet, then a query
    step(1'b1, 8'hA5); step(1'b1, 8'h01);
    idle_n(TO + 3);
    send(8'hA5, 8'h03, 8'h00, 8'hA6, 0);
    idle_n(3);

    // Checksum byte coincides with the vsync edge
    send(8'hA5, 8'h01, 8'h03, 8'hA7, 0);
    step(1'b1, 8'hA5); step(1'b1, 8'h01); step(1'b1, 8'h02);
    vs_force = VSYNC_ACT; step(1'b1, 8'hA6);
    chk("coincident_mode_now", 32'(mode_sel), 32'd3);
    chk("coincident_pending", 32'(pending), 32'd1);
    idle_n(2);
    vs_force = ~VSYNC_ACT; idle_n(3);
    vs_force = VSYNC_ACT; idle_n(2);
    chk("coincident_mode_next", 32'(mode_sel), 32'd2);
    vs_force = ~VSYNC_ACT; idle_n(2);

    // Two responses while TX is stalled: the later byte overwrites
    ack_ready = 1'b0;
    send(8'hA5, 8'h02, 8'h11, 8'hB6, 0);
    send(8'hA5, 8'h03, 8'h00, 8'hA6, 0);
    idle_n(2);
    chk("stall_ack_valid", 32'(ack_valid), 32'd1);
    chk("stall_ack_data", 32'(ack_data), 32'h02);
    ack_ready = 1'b1;
    idle_n(2);

    // Randomized traffic
    vs_auto = 1'b1; rand_rdy = 1'b1;
    for (int p = 0; p < 300; p++) begin
      int kind, gap;
      logic [7:0] c, a, k;
      kind = $urandom_range(0, 9);
      gap  = $urandom_range(0, 3);
      c = 8'h01; a = 8'($urandom_range(1, 3));
      case (kind)
        2:    a = 8'($urandom_range(0, 255));
        3, 4: begin c = 8'h02; a = 8'($urandom_range(0, 255)); end
        5:    begin c = 8'h03; a = 8'($urandom_range(0, 255)); end
        6:    begin c = 8'($urandom_range(0, 255)); a = 8'($urandom_range(0, 255)); end
        default: ;
      endcase
      k = 8'hA5 ^ c ^ a;
      if (kind == 7) k = k ^ 8'($urandom_range(1, 255));
      if (kind == 8) begin
        logic [7:0] g;
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h5A;
        step(1'b1, g);
      end
      if (kind == 9) begin
        int nb;
        logic [7:0] pb[3];
        pb[0] = 8'hA5; pb[1] = c; pb[2] = a;
        nb = $urandom_range(1, 3);
        for (int i = 0; i < nb; i++) begin step(1'b1, pb[i]); idle_n(gap); end
        idle_n(TO + $urandom_range(0, 5));
      end else begin
        send(8'hA5, c, a, k, gap);
      end
      idle_n($urandom_range(0, 4));
    end
    rand_rdy = 1'b0; ack_ready = 1'b1;
    idle_n(80);

    // Reset in the middle of a packet with a change pending
    vs_auto = 1'b0; vs_force = ~VSYNC_ACT;
    send(8'hA5, 8'h01, 8'h03, 8'hA7, 0);
    step(1'b1, 8'hA5); step(1'b1, 8'h02);
    do_reset();
    check_reset_vals();
    idle_n(4);
    vs_force = VSYNC_ACT; idle_n(3);
    chk("post_reset_mode", 32'(mode_sel), 32'd1);
    idle_n(5);

    chk("ack_queue_drained", 32'(exp_ack_q.size()), 32'd0);
    chk("err_queue_drained", 32'(exp_err_q.size()), 32'd0);
    chk("commit_queue_drained", 32'(exp_cm_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
